// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship game blocks: one-hot hazard
// states, the LFSR feedback mask and the repair-code zero substitute.
package nexys_starship_pkg;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_GRACE = 4'b0010;
  localparam logic [3:0] ST_COUNT = 4'b0100;
  localparam logic [3:0] ST_FIRE  = 4'b1000;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [3:0]  HEX_ZERO_SUB = 4'hF;

  // A repair code of zero is not a usable code downstream.
  function automatic logic [3:0] fix_hex(input logic [3:0] h);
    return (h == 4'h0) ? HEX_ZERO_SUB : h;
  endfunction

endpackage

// File: rtl/nexys_starship_lfsr.sv
// Free-running right-shifting Galois LFSR; a zero seed is forced to 1 so the
// register can never lock up.
module nexys_starship_lfsr
  import nexys_starship_pkg::*;
#(
  parameter int                 DATA_W = 16,
  parameter logic [DATA_W-1:0]  MASK   = LFSR_MASK,
  parameter logic [DATA_W-1:0]  SEED   = 16'hACE1
) (
  input  logic              timer_clk,
  input  logic              Reset,
  input  logic              en,
  output logic [DATA_W-1:0] lfsr
);

  localparam logic [DATA_W-1:0] SEED_NZ =
    (SEED == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : SEED;

  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset)
      lfsr <= SEED_NZ;
    else if (en)
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? MASK : '0);
  end

endmodule

// File: rtl/nexys_starship_hazard_gen.sv
// Hazard generator: picks when and which repair station breaks, and its code.
// Optional difficulty ramp enabled by defining HAZARD_RAMP_EN.
module nexys_starship_hazard_gen
  import nexys_starship_pkg::*;
#(
  parameter int         NUM_ST      = 4,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter logic [7:0] GRACE_TICKS = 8'd16,
  parameter logic [7:0] MIN_GAP     = 8'd4,
  parameter logic [7:0] RAMP_TICKS  = 8'd32
) (
  input  logic                  timer_clk,
  input  logic                  Reset,
  input  logic                  play_flag,
  input  logic                  gameover_ctrl,
  input  logic [NUM_ST-1:0]     st_broken,
  output logic [NUM_ST-1:0]     brk_req,
  output logic [4*NUM_ST-1:0]   brk_hex,
  output logic [2:0]            level,
  output logic                  q_Idle,
  output logic                  q_Grace,
  output logic                  q_Count,
  output logic                  q_Fire
);

  localparam logic [7:0] GRACE_LAST = GRACE_TICKS - 8'd1;
  localparam logic [1:0] ST_MASK    = 2'(NUM_ST - 1);

  logic [3:0]        state;
  logic [NUM_ST-1:0] sync1, sb;
  logic [7:0]        grace_cnt, gap_cnt;
  logic [15:0]       lfsr_q;
  logic              abort;
  logic [3:0]        free4;
  logic [1:0]        start, fire_idx;
  logic              found;
  logic [NUM_ST-1:0] fire_vec;
  logic              unused_lfsr_bits;

  assign unused_lfsr_bits = ^lfsr_q[11:10];

  nexys_starship_lfsr #(.DATA_W(16), .MASK(LFSR_MASK), .SEED(SEED)) u_lfsr (
    .timer_clk (timer_clk),
    .Reset     (Reset),
    .en        (1'b1),
    .lfsr      (lfsr_q)
  );

  // Gap sum is 9 bits wide and saturates to the 8-bit counter range.
  function automatic logic [7:0] calc_gap(input logic [7:0] rnd, input logic [2:0] lvl);
    logic [8:0] sum;
    sum = {1'b0, MIN_GAP} + {1'b0, rnd & (8'hFF >> lvl)};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  assign abort = (state != ST_IDLE) && (gameover_ctrl || !play_flag);

  // Rotating scan: lowest offset from the random start wins.
  always_comb begin
    free4 = '0;
    free4[NUM_ST-1:0] = ~brk_req & ~sb;
    start    = lfsr_q[9:8] & ST_MASK;
    found    = 1'b0;
    fire_idx = '0;
    for (int k = NUM_ST - 1; k >= 0; k--) begin
      if (free4[(start + 2'(k)) & ST_MASK]) begin
        found    = 1'b1;
        fire_idx = (start + 2'(k)) & ST_MASK;
      end
    end
    fire_vec = '0;
    for (int i = 0; i < NUM_ST; i++)
      if (found && (fire_idx == 2'(i)))
        fire_vec[i] = 1'b1;
  end

  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      brk_req   <= '0;
      brk_hex   <= '0;
      grace_cnt <= '0;
      gap_cnt   <= '0;
      sync1     <= '0;
      sb        <= '0;
    end else begin
      sync1 <= st_broken;
      sb    <= sync1;
      if (abort) begin
        state     <= ST_IDLE;
        brk_req   <= '0;
        grace_cnt <= '0;
        gap_cnt   <= '0;
      end else begin
        brk_req <= brk_req & ~sb;
        case (state)
          ST_IDLE: begin
            brk_req   <= '0;
            grace_cnt <= '0;
            gap_cnt   <= '0;
            if (play_flag && !gameover_ctrl)
              state <= ST_GRACE;
          end
          ST_GRACE: begin
            if (grace_cnt == GRACE_LAST) begin
              state   <= ST_COUNT;
              gap_cnt <= calc_gap(lfsr_q[7:0], level);
            end else begin
              grace_cnt <= grace_cnt + 8'd1;
            end
          end
          ST_COUNT: begin
            if (gap_cnt == 8'd0)
              state <= ST_FIRE;
            else
              gap_cnt <= gap_cnt - 8'd1;
          end
          ST_FIRE: begin
            if (found) begin
              brk_req <= (brk_req & ~sb) | fire_vec;
              for (int i = 0; i < NUM_ST; i++)
                if (fire_vec[i])
                  brk_hex[4*i +: 4] <= fix_hex(lfsr_q[15:12]);
              state   <= ST_COUNT;
              gap_cnt <= calc_gap(lfsr_q[7:0], level);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef HAZARD_RAMP_EN
  localparam logic [7:0] RAMP_LAST = RAMP_TICKS - 8'd1;
  logic [7:0] ramp_cnt;

  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      ramp_cnt <= '0;
      level    <= '0;
    end else if (abort || (state == ST_IDLE)) begin
      ramp_cnt <= '0;
      level    <= '0;
    end else if ((state == ST_COUNT) || (state == ST_FIRE)) begin
      if (ramp_cnt == RAMP_LAST) begin
        ramp_cnt <= '0;
        if (level != 3'd7)
          level <= level + 3'd1;
      end else begin
        ramp_cnt <= ramp_cnt + 8'd1;
      end
    end
  end
`else
  logic [7:0] unused_ramp_ticks;
  assign unused_ramp_ticks = RAMP_TICKS;
  assign level = 3'd0;
`endif

  assign q_Idle  = state[0];
  assign q_Grace = state[1];
  assign q_Count = state[2];
  assign q_Fire  = state[3];

endmodule

// File: doc/nexys_starship_hazard_gen.md
# nexys_starship_hazard_gen

Hazard generator for Nexys Starship: decides when and which repair station breaks, and with what 4-bit repair code. It sits directly upstream of the per-station repair FSMs (top-repair and siblings), driving their random-break request and random-hex inputs. It runs on the slow `timer_clk` game tick, from a free-running LFSR, with a grace period and an optional difficulty ramp.

## Interface
Parameters:
- `NUM_ST`, 4, number of stations; legal values 1, 2, 4.
- `SEED`, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.
- `GRACE_TICKS`, 16, ticks after play start with no breaks (8-bit, ≥1).
- `MIN_GAP`, 4, minimum ticks between breaks (8-bit).
- `RAMP_TICKS`, 32, ticks per difficulty level step (8-bit, ≥1).

Ports:
- `timer_clk` in 1: game tick clock.
- `Reset` in 1: asynchronous, active-high.
- `play_flag` in 1: game running.
- `gameover_ctrl` in 1: game over; highest priority.
- `st_broken` in NUM_ST: per-station broken flag from the `Clk` domain.
- `brk_req` out NUM_ST: per-station break request, a level held until acknowledged.
- `brk_hex` out 4*NUM_ST: per-station repair code; station i uses bits [4i+3:4i].
- `level` out 3: current difficulty, 0..7.
- `q_Idle`, `q_Grace`, `q_Count`, `q_Fire` out 1 each: one-hot state.

## Operation
- Sync: `st_broken` passes through a 2-flop synchronizer into `timer_clk`; `sb` denotes the synchronized value.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right every tick, including IDLE.
- State machine:
  - IDLE: `brk_req`=0, `level`=0, counters cleared. Go to GRACE when `play_flag`=1 and `gameover_ctrl`=0.
  - GRACE: `grace_cnt` counts up from 0. At `grace_cnt`==GRACE_TICKS-1, go to COUNT and load the gap.
  - COUNT: entry loads `gap_cnt` = MIN_GAP + (lfsr[7:0] & (8'hFF >> level)). The sum is 9-bit and saturates at 255. It decrements each tick. In COUNT with `gap_cnt`==0, go to FIRE.
  - FIRE: `start` = lfsr[9:8] & (NUM_ST-1). Scan start, start+1, … modulo NUM_ST for the first i with `brk_req[i]`==0 and `sb[i]`==0.
    - If found: set `brk_req[i]`=1 and latch `brk_hex[i]` = lfsr[15:12], with 4'h0 mapped to 4'hF. Go to COUNT with a new gap.
    - If none is free: stay in FIRE and rescan each tick.
- Ack: `brk_req[i]` clears on any tick where `sb[i]`=1. `brk_hex[i]` holds until that station's next fire.
- Priority, evaluated every tick from any non-IDLE state: `gameover_ctrl`=1 or `play_flag`=0 → IDLE, clearing all `brk_req` and `level`. This beats fire and ack.
- A station is never fired while requested or broken, so fire and ack can't collide on one station.

## Timing
- Reset values: state IDLE, `brk_req`=0, `brk_hex`=0, `level`=0, LFSR=SEED, sync flops 0.
- All outputs are registered and change only on `timer_clk` rising edges.
- From entering COUNT with gap g to the `brk_req` rise: g+2 ticks, when a station is free.
- From the `play_flag` rise to the first possible `brk_req`: GRACE_TICKS + MIN_GAP + 3 ticks (1 tick IDLE→GRACE).
- Ack latency: `st_broken` rise → `brk_req` fall within 3 ticks (2-flop sync + 1).
- Downstream samples `brk_req` on the fast `Clk`. The level hold makes this CDC-safe; `brk_hex` is stable whenever `brk_req` is 1.

## Configuration
- `HAZARD_RAMP_EN` defined:
  - `ramp_cnt` (8-bit) counts ticks in COUNT/FIRE.
  - At RAMP_TICKS-1 it wraps and `level` increments, saturating at 7.
- Undefined: `level` is tied to 0, so the gap mask is always 8'hFF; no ramp counter is built.

## Structure
- Shared package `nexys_starship_pkg`: state one-hot localparams (IDLE/GRACE/COUNT/FIRE), LFSR mask 16'hB400, the hex zero-substitute 4'hF.
- Sub-module `nexys_starship_lfsr` (width, mask, seed; enable tied high), reusable by other game blocks.
- The synchronizer and the rotating free-station scan stay inline.

## Test plan
- Reset mid-FIRE with `brk_req`=4'b0101 → all outputs 0 and state IDLE on the same cycle (asynchronous); LFSR=16'hACE1.
- `play_flag` rise at tick 0 with `st_broken`=0 → `brk_req` stays 0 through tick 22 (16+4+3-1); the first one-hot request appears on a later tick with a nonzero `brk_hex` nibble.
- Requested station i, drive `st_broken[i]`=1 → `brk_req[i]` falls within 3 ticks; `brk_hex[i]` unchanged.
- `st_broken`=4'hF held → state sits in FIRE, no `brk_req` bits set; release bit 2 → `brk_req[2]` rises within 3 ticks.
- `gameover_ctrl` pulse while COUNT with two requests pending → next tick IDLE, `brk_req`=0, `level`=0.
- With `HAZARD_RAMP_EN`, RAMP_TICKS=32, stations acking promptly → `level`=1 after 32 COUNT/FIRE ticks, saturating at 7 after 224; without the macro, `level`=0 throughout.
